// File: rtl/mem_sys_pkg.sv
// Shared definitions for the mem_sys control slice.
// Contents: command opcodes, sequencer state encoding, default address and
// length widths, the bank count, and a small state-classification helper.
package mem_sys_pkg;

   localparam int XA_W_DEF   = 10;
   localparam int WA_W_DEF   = 20;
   localparam int LEN_W_DEF  = 21;
   localparam int NUM_BANKS  = 4;
   localparam int BANK_SEL_W = $clog2(NUM_BANKS);

   typedef enum logic [1:0] {
      OP_LOAD_X = 2'b00,
      OP_LOAD_W = 2'b01,
      OP_READ   = 2'b10,
      OP_RSVD   = 2'b11
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_X = 3'd1,
      ST_LOAD_W = 3'd2,
      ST_READ   = 3'd3,
      ST_FLUSH  = 3'd4,
      ST_DONE   = 3'd5
   } state_e;

   // True in the two states that accept beats from the host load stream.
   function automatic logic is_load_state(input state_e s);
      return (s == ST_LOAD_X) || (s == ST_LOAD_W);
   endfunction

endpackage

// File: rtl/mem_addr_cnt.sv
// Loadable, wrapping, enable-driven address counter.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (clears to 0)
//   load      : load load_val (takes priority over en)
//   load_val  : start address
//   en        : increment by one, wrapping modulo 2^AW
//   addr      : registered current address
module mem_addr_cnt #(
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [AW-1:0] load_val,
   input  logic          en,
   output logic [AW-1:0] addr
);

   localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

   logic [AW-1:0] addr_r;

   // Address register: load wins over increment; natural overflow gives the wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_r <= {AW{1'b0}};
      end else if (load) begin
         addr_r <= load_val;
      end else if (en) begin
         addr_r <= addr_r + ADDR_ONE;
      end else begin
         addr_r <= addr_r;
      end
   end

   assign addr = addr_r;

endmodule

// File: rtl/mem_sys_ctrl.sv
// Command sequencer owning all control ports of the bit-serial mem_sys store.
// LOAD_X / LOAD_W stream host bits into one bank (one beat per two cycles, each
// write pulse one cycle wide with address and data held stable); READ replays
// paired X/W bits to the MAC datapath under valid/ready. Every output,
// including all mem_sys controls, comes straight from a register.
// Ports:
//   command : cmd_valid/cmd_ready, cmd_op, cmd_bank_x/w, cmd_addr_x/w, cmd_len
//   load    : din_valid, din, din_ready
//   read    : dout_valid, dout_x, dout_w, dout_ready
//   status  : busy (not IDLE), done (one-cycle completion pulse)
//   mem_sys : mem_we_x/w, mem_data_in, mem_address_x/w, mem_sel_x/w,
//             mem_data_out_x/w (combinational read data back)
module mem_sys_ctrl
   import mem_sys_pkg::*;
#(
   parameter int XA_W  = XA_W_DEF,
   parameter int WA_W  = WA_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [BANK_SEL_W-1:0] cmd_bank_x,
   input  logic [BANK_SEL_W-1:0] cmd_bank_w,
   input  logic [XA_W-1:0]       cmd_addr_x,
   input  logic [WA_W-1:0]       cmd_addr_w,
   input  logic [LEN_W-1:0]      cmd_len,
   input  logic                  din_valid,
   input  logic                  din,
   output logic                  din_ready,
   output logic                  dout_valid,
   output logic                  dout_x,
   output logic                  dout_w,
   input  logic                  dout_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  mem_we_x,
   output logic                  mem_we_w,
   output logic                  mem_data_in,
   output logic [XA_W-1:0]       mem_address_x,
   output logic [WA_W-1:0]       mem_address_w,
   output logic [BANK_SEL_W-1:0] mem_sel_x,
   output logic [BANK_SEL_W-1:0] mem_sel_w,
   input  logic                  mem_data_out_x,
   input  logic                  mem_data_out_w
);

   localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   state_e                state_r, state_nx_s;
   logic [LEN_W-1:0]      cnt_r, cnt_nx_s;
   logic [BANK_SEL_W-1:0] sel_x_r, sel_x_nx_s, sel_w_r, sel_w_nx_s;
   logic                  we_x_r, we_x_nx_s, we_w_r, we_w_nx_s;
   logic                  data_in_r, data_in_nx_s;
   logic                  din_ready_r, din_ready_nx_s;
   logic                  dout_valid_r, dout_valid_nx_s;
   logic                  dout_x_r, dout_x_nx_s, dout_w_r, dout_w_nx_s;
   logic                  busy_r, done_r, cmd_ready_r;
   logic                  accept_s, inc_x_s, inc_w_s;

   // Next-state and next-output computation for the whole sequencer.
   always_comb begin
      state_nx_s      = state_r;
      cnt_nx_s        = cnt_r;
      sel_x_nx_s      = sel_x_r;
      sel_w_nx_s      = sel_w_r;
      we_x_nx_s       = 1'b0;
      we_w_nx_s       = 1'b0;
      data_in_nx_s    = data_in_r;
      dout_valid_nx_s = dout_valid_r;
      dout_x_nx_s     = dout_x_r;
      dout_w_nx_s     = dout_w_r;
      accept_s        = 1'b0;
      inc_x_s         = 1'b0;
      inc_w_s         = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_r) begin
               accept_s   = 1'b1;
               sel_x_nx_s = cmd_bank_x;
               sel_w_nx_s = cmd_bank_w;
               cnt_nx_s   = cmd_len;
               if (cmd_len == CNT_ZERO) begin
                  state_nx_s = ST_DONE;
               end else begin
                  case (cmd_op_e'(cmd_op))
                     OP_LOAD_X: state_nx_s = ST_LOAD_X;
                     OP_LOAD_W: state_nx_s = ST_LOAD_W;
                     OP_READ:   state_nx_s = ST_READ;
                     default:   state_nx_s = ST_DONE;
                  endcase
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end

         // Address advances on the cycle after each write pulse.
         ST_LOAD_X: begin
            inc_x_s = we_x_r;
            if (din_valid && din_ready_r) begin
               data_in_nx_s = din;
               we_x_nx_s    = 1'b1;
               cnt_nx_s     = cnt_r - CNT_ONE;
               if (cnt_r == CNT_ONE) begin
                  state_nx_s = ST_FLUSH;
               end else begin
                  state_nx_s = ST_LOAD_X;
               end
            end else begin
               state_nx_s = ST_LOAD_X;
            end
         end

         ST_LOAD_W: begin
            inc_w_s = we_w_r;
            if (din_valid && din_ready_r) begin
               data_in_nx_s = din;
               we_w_nx_s    = 1'b1;
               cnt_nx_s     = cnt_r - CNT_ONE;
               if (cnt_r == CNT_ONE) begin
                  state_nx_s = ST_FLUSH;
               end else begin
                  state_nx_s = ST_LOAD_W;
               end
            end else begin
               state_nx_s = ST_LOAD_W;
            end
         end

         // Final write pulse is live during this cycle; step its address afterwards.
         ST_FLUSH: begin
            inc_x_s    = we_x_r;
            inc_w_s    = we_w_r;
            state_nx_s = ST_DONE;
         end

         ST_READ: begin
            if ((cnt_r != CNT_ZERO) && (!dout_valid_r || dout_ready)) begin
               dout_x_nx_s     = mem_data_out_x;
               dout_w_nx_s     = mem_data_out_w;
               dout_valid_nx_s = 1'b1;
               inc_x_s         = 1'b1;
               inc_w_s         = 1'b1;
               cnt_nx_s        = cnt_r - CNT_ONE;
               state_nx_s      = ST_READ;
            end else if (dout_ready || !dout_valid_r) begin
               // No advance here implies cnt is exhausted: last beat consumed.
               dout_valid_nx_s = 1'b0;
               if (cnt_r == CNT_ZERO) begin
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_READ;
               end
            end else begin
               state_nx_s = ST_READ;
            end
         end

         ST_DONE: begin
            state_nx_s = ST_IDLE;
         end

         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase

      // Ready drops during a write pulse, giving one beat per two cycles.
      din_ready_nx_s = is_load_state(state_nx_s) && (cnt_nx_s != CNT_ZERO) &&
                       !(we_x_nx_s || we_w_nx_s);
   end

   // State and output registers; reset drops any write pulse immediately.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         cnt_r        <= CNT_ZERO;
         sel_x_r      <= {BANK_SEL_W{1'b0}};
         sel_w_r      <= {BANK_SEL_W{1'b0}};
         we_x_r       <= 1'b0;
         we_w_r       <= 1'b0;
         data_in_r    <= 1'b0;
         din_ready_r  <= 1'b0;
         dout_valid_r <= 1'b0;
         dout_x_r     <= 1'b0;
         dout_w_r     <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
         cmd_ready_r  <= 1'b1;
      end else begin
         state_r      <= state_nx_s;
         cnt_r        <= cnt_nx_s;
         sel_x_r      <= sel_x_nx_s;
         sel_w_r      <= sel_w_nx_s;
         we_x_r       <= we_x_nx_s;
         we_w_r       <= we_w_nx_s;
         data_in_r    <= data_in_nx_s;
         din_ready_r  <= din_ready_nx_s;
         dout_valid_r <= dout_valid_nx_s;
         dout_x_r     <= dout_x_nx_s;
         dout_w_r     <= dout_w_nx_s;
         busy_r       <= (state_nx_s != ST_IDLE);
         done_r       <= (state_nx_s == ST_DONE);
         cmd_ready_r  <= (state_nx_s == ST_IDLE);
      end
   end

   mem_addr_cnt #(.AW(XA_W)) u_addr_x (
      .clk      (clk),
      .rst      (rst),
      .load     (accept_s),
      .load_val (cmd_addr_x),
      .en       (inc_x_s),
      .addr     (mem_address_x)
   );

   mem_addr_cnt #(.AW(WA_W)) u_addr_w (
      .clk      (clk),
      .rst      (rst),
      .load     (accept_s),
      .load_val (cmd_addr_w),
      .en       (inc_w_s),
      .addr     (mem_address_w)
   );

   assign cmd_ready   = cmd_ready_r;
   assign din_ready   = din_ready_r;
   assign dout_valid  = dout_valid_r;
   assign dout_x      = dout_x_r;
   assign dout_w      = dout_w_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign mem_we_x    = we_x_r;
   assign mem_we_w    = we_w_r;
   assign mem_data_in = data_in_r;
   assign mem_sel_x   = sel_x_r;
   assign mem_sel_w   = sel_w_r;

endmodule

// File: tb/tb_mem_sys_ctrl.sv
// Self-checking bench for mem_sys_ctrl with a behavioural mem_sys model and a
// reference memory image driven from the intended command stream.
module tb_mem_sys_ctrl;

   localparam int XD = 1024;
   localparam int WD = 1048576;

   logic        clk = 1'b0;
   logic        rst, cmd_valid, cmd_ready;
   logic [1:0]  cmd_op, cmd_bank_x, cmd_bank_w;
   logic [9:0]  cmd_addr_x;
   logic [19:0] cmd_addr_w;
   logic [20:0] cmd_len;
   logic        din_valid, din, din_ready;
   logic        dout_valid, dout_x, dout_w, dout_ready;
   logic        busy, done;
   logic        mem_we_x, mem_we_w, mem_data_in;
   logic [9:0]  mem_address_x;
   logic [19:0] mem_address_w;
   logic [1:0]  mem_sel_x, mem_sel_w;
   logic        mem_data_out_x, mem_data_out_w;

   always #5 clk = ~clk;

   mem_sys_ctrl dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_bank_x(cmd_bank_x), .cmd_bank_w(cmd_bank_w),
      .cmd_addr_x(cmd_addr_x), .cmd_addr_w(cmd_addr_w), .cmd_len(cmd_len),
      .din_valid(din_valid), .din(din), .din_ready(din_ready),
      .dout_valid(dout_valid), .dout_x(dout_x), .dout_w(dout_w),
      .dout_ready(dout_ready), .busy(busy), .done(done),
      .mem_we_x(mem_we_x), .mem_we_w(mem_we_w), .mem_data_in(mem_data_in),
      .mem_address_x(mem_address_x), .mem_address_w(mem_address_w),
      .mem_sel_x(mem_sel_x), .mem_sel_w(mem_sel_w),
      .mem_data_out_x(mem_data_out_x), .mem_data_out_w(mem_data_out_w)
   );

   // Behavioural mem_sys: level write sampled per cycle, combinational read.
   bit mem_x [0:3][0:XD-1];
   bit mem_w [0:3][0:WD-1];
   always @(posedge clk) begin
      if (mem_we_x) mem_x[mem_sel_x][mem_address_x] <= mem_data_in;
      if (mem_we_w) mem_w[mem_sel_w][mem_address_w] <= mem_data_in;
   end
   assign mem_data_out_x = mem_x[mem_sel_x][mem_address_x];
   assign mem_data_out_w = mem_w[mem_sel_w][mem_address_w];

   // Reference image of what the host intended to store.
   bit ref_x [0:3][0:XD-1];
   bit ref_w [0:3][0:WD-1];

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic        is_x;
      logic [1:0]  bank;
      logic [19:0] addr;
      logic        d;
   } wr_t;

   wr_t        wr_q[$];
   logic [1:0] rd_q[$];
   int         done_cnt = 0;
   logic       prev_hs = 1'b0, prev_din = 1'b0, prev_stall = 1'b0;
   logic       prev_x = 1'b0, prev_w = 1'b0;

   // Monitor on the falling edge: write-pulse timing, write log, read log, stall stability.
   always @(negedge clk) begin
      if (rst) begin
         prev_hs    <= 1'b0;
         prev_stall <= 1'b0;
      end else begin
         if (mem_we_x || mem_we_w || prev_hs) begin
            check("we_after_beat", {31'b0, mem_we_x | mem_we_w}, {31'b0, prev_hs});
            if (prev_hs) check("we_data", {31'b0, mem_data_in}, {31'b0, prev_din});
         end
         if (mem_we_x) wr_q.push_back({1'b1, mem_sel_x, {10'b0, mem_address_x}, mem_data_in});
         if (mem_we_w) wr_q.push_back({1'b0, mem_sel_w, mem_address_w, mem_data_in});
         if (dout_valid && dout_ready) rd_q.push_back({dout_x, dout_w});
         if (prev_stall)
            check("stall_stable", {29'b0, dout_valid, dout_x, dout_w}, {29'b0, 1'b1, prev_x, prev_w});
         if (done) done_cnt <= done_cnt + 1;
         prev_hs    <= din_valid && din_ready;
         prev_din   <= din;
         prev_stall <= dout_valid && !dout_ready;
         prev_x     <= dout_x;
         prev_w     <= dout_w;
      end
   end

   typedef struct {
      logic [1:0]  op;
      logic [1:0]  bx, bw;
      logic [9:0]  ax;
      logic [19:0] aw;
      logic [20:0] len;
      logic [63:0] pat;
      bit          rdy_rand;
      int          exp_writes;
      int          exp_beats;
   } vec_t;

   vec_t vecs[11];

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [1:0] bx, input logic [1:0] bw,
                        input logic [9:0] ax, input logic [19:0] aw, input logic [20:0] len);
      int w = 0;
      while (!cmd_ready && w < 200) begin cyc(); w++; end
      if (w >= 200) check("cmd_wait_timeout", 32'd0, 32'd1);
      cmd_op = op; cmd_bank_x = bx; cmd_bank_w = bw;
      cmd_addr_x = ax; cmd_addr_w = aw; cmd_len = len;
      cmd_valid = 1'b1;
      cyc();
      cmd_valid = 1'b0;
   endtask

   task automatic model_load(input bit is_x, input int bank, input int base, input int len,
                             input logic [63:0] pat);
      for (int i = 0; i < len; i++) begin
         if (is_x) ref_x[bank][(base + i) % XD] = pat[i % 64];
         else      ref_w[bank][(base + i) % WD] = pat[i % 64];
      end
   endtask

   task automatic run_cmd(input vec_t v);
      int  wb, rb, db, idx, n, bank, base;
      bit  is_load, is_x, hs;
      logic [1:0] er;
      wr_t ew;
      is_load = (v.op == 2'b00) || (v.op == 2'b01);
      is_x    = (v.op == 2'b00);
      wb = wr_q.size(); rb = rd_q.size(); db = done_cnt;
      issue(v.op, v.bx, v.bw, v.ax, v.aw, v.len);
      if (v.len == 21'd0 || v.op == 2'b11) check("zero_done_next_cycle", {31'b0, done}, 32'd1);
      idx = 0; n = 0;
      while (!(cmd_ready && (!is_load || idx >= int'(v.len))) && n < 10000) begin
         if (is_load && idx < int'(v.len)) begin
            din_valid = ($urandom % 4) != 0;
            din       = din_valid ? v.pat[idx % 64] : 1'($urandom);
         end else begin
            din_valid = 1'($urandom);
            din       = 1'($urandom);
         end
         dout_ready = v.rdy_rand ? 1'($urandom) : 1'b1;
         hs = din_valid && din_ready && is_load && idx < int'(v.len);
         cyc();
         if (hs) idx++;
         n++;
      end
      din_valid = 1'b0; dout_ready = 1'b1;
      if (n >= 10000) check("cmd_timeout", 32'd0, 32'd1);
      check("done_count", done_cnt - db, 32'd1);
      check("n_writes", wr_q.size() - wb, v.exp_writes);
      bank = is_x ? int'(v.bx) : int'(v.bw);
      base = is_x ? int'(v.ax) : int'(v.aw);
      for (int i = 0; i < v.exp_writes && wb + i < wr_q.size(); i++) begin
         ew.is_x = is_x;
         ew.bank = 2'(bank);
         ew.addr = is_x ? 20'((base + i) % XD) : 20'((base + i) % WD);
         ew.d    = v.pat[i % 64];
         check($sformatf("write_%0d", i), {8'b0, wr_q[wb + i]}, {8'b0, ew});
      end
      check("n_beats", rd_q.size() - rb, v.exp_beats);
      for (int i = 0; i < v.exp_beats && rb + i < rd_q.size(); i++) begin
         er = {ref_x[v.bx][(int'(v.ax) + i) % XD], ref_w[v.bw][(int'(v.aw) + i) % WD]};
         check($sformatf("beat_%0d", i), {30'b0, rd_q[rb + i]}, {30'b0, er});
      end
      if (is_load) model_load(is_x, bank, base, int'(v.len), v.pat);
   endtask

   initial begin
      int idx, n, db, wb;
      bit hs;
      logic [7:0] a5;
      vec_t rv;
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_bank_x = 2'b00; cmd_bank_w = 2'b00;
      cmd_addr_x = 10'h0; cmd_addr_w = 20'h0; cmd_len = 21'd0;
      din_valid = 1'b0; din = 1'b0; dout_ready = 1'b1;
      repeat (3) cyc();
      check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      check("rst_ctrl", {23'b0, din_ready, dout_valid, busy, done, mem_we_x, mem_we_w,
                         mem_data_in, dout_x, dout_w}, 32'd0);
      check("rst_addr", {2'b0, mem_address_x, mem_address_w}, 32'd0);
      check("rst_sel", {28'b0, mem_sel_x, mem_sel_w}, 32'd0);
      rst = 1'b0;
      cyc();

      vecs[0]  = '{2'b00, 2'd2, 2'd0, 10'h3FE, 20'h00000, 21'd4,    64'hD,   1'b0, 4,    0};
      vecs[1]  = '{2'b01, 2'd0, 2'd1, 10'h000, 20'h00010, 21'd8,    64'hA5,  1'b0, 8,    0};
      vecs[2]  = '{2'b10, 2'd0, 2'd1, 10'h000, 20'h00010, 21'd8,    64'h0,   1'b0, 0,    8};
      vecs[3]  = '{2'b01, 2'd0, 2'd3, 10'h000, 20'hFFFFE, 21'd5,    64'h16,  1'b0, 5,    0};
      vecs[4]  = '{2'b10, 2'd2, 2'd3, 10'h3FE, 20'hFFFFE, 21'd16,   64'h0,   1'b1, 0,    16};
      vecs[5]  = '{2'b11, 2'd1, 2'd1, 10'h005, 20'h00005, 21'd7,    64'h0,   1'b1, 0,    0};
      vecs[6]  = '{2'b00, 2'd1, 2'd0, 10'h010, 20'h00000, 21'd0,    64'h1,   1'b0, 0,    0};
      vecs[7]  = '{2'b01, 2'd0, 2'd2, 10'h000, 20'h00020, 21'd0,    64'h1,   1'b0, 0,    0};
      vecs[8]  = '{2'b10, 2'd0, 2'd1, 10'h000, 20'h00010, 21'd0,    64'h0,   1'b0, 0,    0};
      vecs[9]  = '{2'b00, 2'd3, 2'd0, 10'h000, 20'h00000, 21'd1026,
                   64'h0123_4567_89AB_CDEF, 1'b0, 1026, 0};
      vecs[10] = '{2'b10, 2'd3, 2'd0, 10'h3FF, 20'h00000, 21'd4,    64'h0,   1'b1, 0,    4};
      for (int i = 0; i < 11; i++) run_cmd(vecs[i]);

      // Read latency and throughput on the 0xA5 pattern in W bank 1.
      a5 = 8'hA5;
      dout_ready = 1'b1;
      issue(2'b10, 2'd0, 2'd1, 10'h000, 20'h00010, 21'd8);
      check("rd_lat_not_yet", {31'b0, dout_valid}, 32'd0);
      for (int k = 0; k < 8; k++) begin
         cyc();
         check($sformatf("rd_seq_%0d", k), {30'b0, dout_valid, dout_w}, {30'b0, 1'b1, a5[k]});
      end
      cyc();
      check("rd_seq_done", {30'b0, done, dout_valid}, {30'b0, 2'b10});
      cyc();
      check("rd_seq_idle", {31'b0, cmd_ready}, 32'd1);

      // Command held while busy: accepted on the first IDLE cycle only.
      db = done_cnt; wb = wr_q.size();
      issue(2'b00, 2'd1, 2'd0, 10'h100, 20'h0, 21'd3);
      cmd_op = 2'b11; cmd_len = 21'd5; cmd_valid = 1'b1;
      idx = 0; n = 0;
      while (idx < 3 && n < 100) begin
         din_valid = 1'b1; din = (idx != 1);
         hs = din_ready;
         cyc();
         if (hs) idx++;
         n++;
      end
      din_valid = 1'b0;
      n = 0;
      while (!done && n < 20) begin cyc(); n++; end
      check("busy_first_done", {31'b0, done}, 32'd1);
      check("busy_not_taken", done_cnt - db, 32'd0);
      cyc();
      check("busy_idle_ready", {31'b0, cmd_ready}, 32'd1);
      cyc();
      cmd_valid = 1'b0;
      check("busy_accept_done", {30'b0, done, cmd_ready}, {30'b0, 2'b10});
      cyc();
      check("busy_done_pulses", done_cnt - db, 32'd2);
      check("busy_writes", wr_q.size() - wb, 32'd3);
      model_load(1'b1, 1, 10'h100, 3, 64'h5);

      // Reset in the middle of a LOAD_X, right after beat 5 is taken.
      db = done_cnt;
      issue(2'b00, 2'd0, 2'd0, 10'h200, 20'h0, 21'd10);
      idx = 0; n = 0;
      while (idx < 5 && n < 100) begin
         din_valid = 1'b1; din = idx[0];
         hs = din_ready;
         cyc();
         if (hs) idx++;
         n++;
      end
      din_valid = 1'b0;
      check("rst_mid_we_live", {31'b0, mem_we_x}, 32'd1);
      rst = 1'b1;
      cyc();
      check("rst_mid_state", {28'b0, mem_we_x, cmd_ready, busy, done}, {28'b0, 4'b0100});
      rst = 1'b0;
      repeat (4) cyc();
      check("rst_mid_no_done", done_cnt - db, 32'd0);
      check("rst_mid_idle", {31'b0, cmd_ready}, 32'd1);
      model_load(1'b1, 0, 10'h200, 5, 64'hAAAA_AAAA_AAAA_AAAA);

      // Randomised command mix.
      for (int r = 0; r < 12; r++) begin
         rv.op  = 2'($urandom);
         rv.bx  = 2'($urandom);
         rv.bw  = 2'($urandom);
         rv.ax  = ($urandom % 2) ? (10'h3F8 + 10'($urandom % 8)) : 10'($urandom);
         rv.aw  = ($urandom % 2) ? (20'hFFFF8 + 20'($urandom % 8)) : 20'($urandom % 256);
         rv.len = ($urandom % 6 == 0) ? 21'd0 : 21'($urandom_range(1, 20));
         rv.pat = {$urandom, $urandom};
         rv.rdy_rand   = 1'b1;
         rv.exp_writes = (rv.op == 2'b00 || rv.op == 2'b01) ? int'(rv.len) : 0;
         rv.exp_beats  = (rv.op == 2'b10) ? int'(rv.len) : 0;
         run_cmd(rv);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
